fp_mul_pipe: RTL and testbench



---
 rtl/fp_mul_pipe.sv | 239 +++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with RNE rounding, special values, saturation and flags.
// Optional macro FP_MUL_SUBNORM_EN enables gradual underflow and subnormal operands (default: flush to zero).

module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [EXP_W+MAN_W:0] a_i,
    input  logic [EXP_W+MAN_W:0] b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [EXP_W+MAN_W:0] result_o,
    output logic [3:0]           flags_o
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SIGW = MAN_W + 1;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int SW   = EXP_W + 2;
    localparam int LZW  = $clog2(PW + 1);
    localparam int XW   = SW + LZW + 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic             en;
    logic             init_q;

    // stage 1: unpack / classify
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
    logic [MAN_W-1:0] fa, fb;
    logic             a_ez, b_ez, a_eo, b_eo;
    logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic             s1_sign_d, s1_spec_d;
    logic [SW-1:0]    s1_exp_d;
    logic [SIGW-1:0]  s1_siga_d, s1_sigb_d;
    logic [W-1:0]     s1_sres_d;
    logic [3:0]       s1_sflg_d;

    logic             s1_v_q, s1_sign_q, s1_spec_q;
    logic [SW-1:0]    s1_exp_q;
    logic [SIGW-1:0]  s1_siga_q, s1_sigb_q;
    logic [W-1:0]     s1_sres_q;
    logic [3:0]       s1_sflg_q;

    // stage 2: significand product
    logic [PW-1:0]    s2_prod_d;
    logic             s2_v_q, s2_sign_q, s2_spec_q;
    logic [SW-1:0]    s2_exp_q;
    logic [PW-1:0]    s2_prod_q;
    logic [W-1:0]     s2_sres_q;
    logic [3:0]       s2_sflg_q;

    // stage 3: normalise / round / pack
    logic [LZW-1:0]   lz;
    logic [PW-1:0]    norm, rvec;
    logic [XW-1:0]    e_n, exp_f;
    logic [SIGW-1:0]  mant;
    logic [SIGW:0]    mant_r;
    logic [MAN_W-1:0] frac;
    logic             g, st, rup, ovf;
    logic [W-1:0]     res_d;
    logic [3:0]       flg_d;
`ifdef FP_MUL_SUBNORM_EN
    logic             tiny;
    logic [XW-1:0]    sh;
    logic [PW-1:0]    lost;
`endif

    logic             out_v_q;
    logic [W-1:0]     res_q;
    logic [3:0]       flg_q;

    assign en          = out_ready_i | ~out_v_q;
    assign in_ready_o  = en & init_q;
    assign out_valid_o = out_v_q;
    assign result_o    = res_q;
    assign flags_o     = flg_q;

    assign {sa, ea, fa} = a_i;
    assign {sb, eb, fb} = b_i;

    always_comb begin
        a_ez   = (ea == '0);
        b_ez   = (eb == '0);
        a_eo   = (ea == '1);
        b_eo   = (eb == '1);
        a_nan  = a_eo & (fa != '0);
        b_nan  = b_eo & (fb != '0);
        a_snan = a_nan & ~fa[MAN_W-1];
        b_snan = b_nan & ~fb[MAN_W-1];
        a_inf  = a_eo & (fa == '0);
        b_inf  = b_eo & (fb == '0);
`ifdef FP_MUL_SUBNORM_EN
        a_zero = a_ez & (fa == '0);
        b_zero = b_ez & (fb == '0);
`else
        a_zero = a_ez;
        b_zero = b_ez;
`endif
        // subnormals sit at exponent 1 with a clear hidden bit
        ea_eff    = a_ez ? EXP_W'(1) : ea;
        eb_eff    = b_ez ? EXP_W'(1) : eb;
        s1_sign_d = sa ^ sb;
        s1_exp_d  = SW'(ea_eff) + SW'(eb_eff) - SW'(BIAS);
        s1_siga_d = {~a_ez, fa};
        s1_sigb_d = {~b_ez, fb};

        s1_spec_d = 1'b0;
        s1_sres_d = '0;
        s1_sflg_d = 4'b0000;
        if (a_nan | b_nan) begin
            s1_spec_d = 1'b1;
            s1_sres_d = QNAN;
            s1_sflg_d = {a_snan | b_snan, 3'b000};
        end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
            s1_spec_d = 1'b1;
            s1_sres_d = QNAN;
            s1_sflg_d = 4'b1000;
        end else if (a_inf | b_inf) begin
            s1_spec_d = 1'b1;
            s1_sres_d = {s1_sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero | b_zero) begin
            s1_spec_d = 1'b1;
            s1_sres_d = {s1_sign_d, {(W-1){1'b0}}};
        end
    end

    assign s2_prod_d = PW'(s1_siga_q) * PW'(s1_sigb_q);

    always_comb begin
        lz = '0;
        for (int i = 0; i < PW; i++) begin
            if (s2_prod_q[i]) lz = LZW'(PW - 1 - i);
        end
        // leading one lands on bit PW-1; exponent accounts for the 2-bit integer field
        norm = s2_prod_q << lz;
        e_n  = {{(XW-SW){s2_exp_q[SW-1]}}, s2_exp_q} + XW'(1) - XW'(lz);
        rvec = norm;
`ifdef FP_MUL_SUBNORM_EN
        tiny = e_n[XW-1] | (e_n == '0);
        sh   = XW'(1) - e_n;
        lost = '0;
        if (tiny) begin
            if (sh >= XW'(PW)) begin
                rvec    = '0;
                rvec[0] = |norm;
            end else begin
                lost    = norm & ~({PW{1'b1}} << sh);
                rvec    = norm >> sh;
                rvec[0] = rvec[0] | (|lost);
            end
        end
`endif
        mant   = rvec[PW-1:MAN_W+1];
        g      = rvec[MAN_W];
        st     = |rvec[MAN_W-1:0];
        rup    = g & (st | mant[0]);
        mant_r = {1'b0, mant} + (SIGW+1)'(rup);
        frac   = mant_r[SIGW] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
`ifdef FP_MUL_SUBNORM_EN
        exp_f  = tiny ? XW'(mant_r[MAN_W]) : e_n + XW'(mant_r[SIGW]);
`else
        exp_f  = e_n + XW'(mant_r[SIGW]);
`endif
        ovf    = ~exp_f[XW-1] & (exp_f >= XW'(EMAX));

        res_d = {s2_sign_q, exp_f[EXP_W-1:0], frac};
        flg_d = {3'b000, g | st};
        if (s2_spec_q) begin
            res_d = s2_sres_q;
            flg_d = s2_sflg_q;
        end else if (ovf) begin
            res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_d = 4'b0101;
`ifdef FP_MUL_SUBNORM_EN
        end else if (tiny) begin
            flg_d[1] = g | st;
`else
        end else if (exp_f[XW-1] | (exp_f == '0)) begin
            res_d = {s2_sign_q, {(W-1){1'b0}}};
            flg_d = {2'b00, 1'b1, g | st};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q    <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_spec_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_siga_q <= '0;
            s1_sigb_q <= '0;
            s1_sres_q <= '0;
            s1_sflg_q <= '0;
            s2_v_q    <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_spec_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_prod_q <= '0;
            s2_sres_q <= '0;
            s2_sflg_q <= '0;
            out_v_q   <= 1'b0;
            res_q     <= '0;
            flg_q     <= '0;
        end else begin
            init_q <= 1'b1;
            if (en) begin
                s1_v_q    <= in_valid_i & init_q;
                s1_sign_q <= s1_sign_d;
                s1_spec_q <= s1_spec_d;
                s1_exp_q  <= s1_exp_d;
                s1_siga_q <= s1_siga_d;
                s1_sigb_q <= s1_sigb_d;
                s1_sres_q <= s1_sres_d;
                s1_sflg_q <= s1_sflg_d;
                s2_v_q    <= s1_v_q;
                s2_sign_q <= s1_sign_q;
                s2_spec_q <= s1_spec_q;
                s2_exp_q  <= s1_exp_q;
                s2_prod_q <= s2_prod_d;
                s2_sres_q <= s1_sres_q;
                s2_sflg_q <= s1_sflg_q;
                out_v_q   <= s2_v_q;
                if (s2_v_q) begin
                    res_q <= res_d;
                    flg_q <= flg_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe (single precision), hand-computed expectations.

module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_vec = 0;
    int n_err = 0;

    fp_mul_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .flags_o    (flags)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NA [6] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001,
                                       32'h3F800001, 32'h3F800003, 32'h7F7FFFFF};
    localparam logic [31:0] NB [6] = '{32'h40000000, 32'h40400000, 32'h3F800001,
                                       32'h3FC00000, 32'h3FC00000, 32'h3F800000};
    localparam logic [31:0] NR [6] = '{32'h40400000, 32'hC0C00000, 32'h3F800002,
                                       32'h3FC00002, 32'h3FC00004, 32'h7F7FFFFF};
    localparam logic [3:0]  NF [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};

    localparam logic [31:0] SA [7] = '{32'h7F000000, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800001,
                                       32'h7FC00001, 32'h7F800000, 32'h00000000};
    localparam logic [31:0] SB [7] = '{32'h40000000, 32'h3F800001, 32'h00000000, 32'h3F800000,
                                       32'h3F800000, 32'hC0000000, 32'hC0400000};
    localparam logic [31:0] SR [7] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                                       32'h7FC00000, 32'hFF800000, 32'h80000000};
    localparam logic [3:0]  SF [7] = '{4'b0101, 4'b0101, 4'b1000, 4'b1000,
                                       4'b0000, 4'b0000, 4'b0000};

    localparam logic [31:0] UA [4] = '{32'h00800000, 32'h80800000, 32'h00800000, 32'h00400000};
    localparam logic [31:0] UB [4] = '{32'h3F000000, 32'h3F000000, 32'h00800000, 32'h40000000};
`ifdef FP_MUL_SUBNORM_EN
    localparam logic [31:0] UR [4] = '{32'h00400000, 32'h80400000, 32'h00000000, 32'h00800000};
    localparam logic [3:0]  UF [4] = '{4'b0000, 4'b0000, 4'b0011, 4'b0000};
`else
    localparam logic [31:0] UR [4] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};
    localparam logic [3:0]  UF [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000};
`endif

    localparam logic [31:0] BA [6] = '{32'h3FC00000, 32'hC0000000, 32'h40000000,
                                       32'h3F800000, 32'h3F000000, 32'h40400000};
    localparam logic [31:0] BB [6] = '{32'h40000000, 32'h40400000, 32'h40000000,
                                       32'h3F800000, 32'h40800000, 32'h40400000};
    localparam logic [31:0] BR [6] = '{32'h40400000, 32'hC0C00000, 32'h40800000,
                                       32'h3F800000, 32'h40000000, 32'h41100000};

    // Presents one operand pair on an idle pipe and returns the result and the
    // number of rising edges from acceptance until out_valid (bounded).
    task automatic issue_op(input logic [31:0] av, input logic [31:0] bv,
                            output logic [31:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = result;
        f = flags;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got out_valid=%b result=%h flags=%b in_ready=%b, want 0 00000000 0000 0",
                     out_valid, result, flags, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_first_edge: got in_ready=%b, want 0", in_ready);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_release: got in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_normal();
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            issue_op(NA[i], NB[i], r, f, lat);
            n_vec++;
            if (r !== NR[i] || f !== NF[i] || lat != 3) begin
                n_err++;
                $display("FAIL normal[%0d] a=%h b=%h: got result=%h flags=%b latency=%0d, want result=%h flags=%b latency=3",
                         i, NA[i], NB[i], r, f, lat, NR[i], NF[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            issue_op(SA[i], SB[i], r, f, lat);
            n_vec++;
            if (r !== SR[i] || f !== SF[i] || lat != 3) begin
                n_err++;
                $display("FAIL special[%0d] a=%h b=%h: got result=%h flags=%b latency=%0d, want result=%h flags=%b latency=3",
                         i, SA[i], SB[i], r, f, lat, SR[i], SF[i]);
            end
        end
    endtask

    task automatic test_underflow();
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            issue_op(UA[i], UB[i], r, f, lat);
            n_vec++;
            if (r !== UR[i] || f !== UF[i] || lat != 3) begin
                n_err++;
                $display("FAIL underflow[%0d] a=%h b=%h: got result=%h flags=%b latency=%0d, want result=%h flags=%b latency=3",
                         i, UA[i], UB[i], r, f, lat, UR[i], UF[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nin = 0;
        int nout = 0;
        int cyc = 0;
        int acc_at_drop = -1;
        while (nout < 6 && cyc < 40) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid = (nin < 6);
            if (nin < 6) begin
                a = BA[nin];
                b = BB[nin];
            end
            #1;
            if (out_valid && nout < 6) begin
                n_vec++;
                if (result !== BR[nout] || flags !== 4'b0000) begin
                    n_err++;
                    $display("FAIL b2b_out[%0d] cycle=%0d: got result=%h flags=%b, want result=%h flags=0000",
                             nout, cyc, result, flags, BR[nout]);
                end
            end
            if (!in_ready && acc_at_drop < 0) acc_at_drop = nin;
            if (in_valid && in_ready) nin++;
            if (out_valid && out_ready) nout++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (acc_at_drop != 3 || nin != 6 || nout != 6) begin
            n_err++;
            $display("FAIL b2b_counts: got accepted_before_stall=%0d accepted=%0d delivered=%0d, want 3 6 6",
                     acc_at_drop, nin, nout);
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_extra_output: got out_valid=%b result=%h after all 6 delivered, want out_valid=0",
                         out_valid, result);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        int          spurious = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 32'h3FC00000;
        b = 32'h40000000;
        @(negedge clk);
        a = 32'h40000000;
        b = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midop_first_out: got out_valid=%b, want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
            n_err++;
            $display("FAIL midop_reset_clear: got out_valid=%b result=%h flags=%b, want 0 00000000 0000",
                     out_valid, result, flags);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) spurious++;
        end
        n_vec++;
        if (spurious != 0) begin
            n_err++;
            $display("FAIL midop_discard: got %0d cycles with out_valid after reset, want 0", spurious);
        end
        issue_op(32'h40400000, 32'h40400000, r, f, lat);
        n_vec++;
        if (r !== 32'h41100000 || f !== 4'b0000 || lat != 3) begin
            n_err++;
            $display("FAIL midop_recover: got result=%h flags=%b latency=%0d, want result=41100000 flags=0000 latency=3",
                     r, f, lat);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_underflow();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
